result_writeback: RTL and testbench
===================================

Name: result_writeback

Overview:
- Receiving end of the PE result path: accepts the 4-byte packed words a PE emits when its shift register is finalized, and writes them into the shared 4-byte-wide result memory.
- Writes go to consecutive addresses from a programmed base.
- A small FIFO decouples PE finalize timing from memory write stalls.
- One instance per PE; the top-level controller starts it per output tile and waits on done.

Parameters:
- ADDR_W, 10, width of memory word address.
- FIFO_DEPTH, 4, result words buffered (power of 2, >=2).
- CNT_W, 10, width of word-count register.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; latches base_addr, num_words.
- base_addr  input  ADDR_W  first write address.
- num_words  input  CNT_W  words to write for this tile; 0 is legal.
- res_valid  input  1  PE word valid (tied to finalize pulse).
- res_data  input  4x8 (unpacked [0:3])  PE packed result word.
- res_ready  output  1  FIFO can accept a word this cycle.
- mem_ready  input  1  memory accepts the write this cycle.
- mem_wr_en  output  1  write request.
- mem_addr  output  ADDR_W  write address.
- mem_data_in  output  4x8 (unpacked [0:3])  write data; byte i maps to lane i.
- busy  output  1  tile in progress.
- done  output  1  one-cycle pulse after the last write is accepted.
- overflow  output  1  sticky: res_valid seen while res_ready=0.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0; overflow cleared.
- States:
  - IDLE: busy=0. start -> latch base/num, clear overflow. num_words==0 -> DONE, else RUN.
  - RUN: busy=1. Push when res_valid&&res_ready. Pop when mem_wr_en&&mem_ready. Accepted-write count reaching num_words -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- FIFO:
  - res_ready = (state==RUN) && (!full || pop this cycle); simultaneous push on full+pop allowed.
  - Words arriving in IDLE/DONE are dropped and set overflow.
  - Words pushed beyond num_words are also dropped and set overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Memory side:
  - mem_wr_en = (state==RUN) && !empty. mem_data_in/mem_addr come combinationally from FIFO head and address counter.
  - mem_data_in and mem_addr must hold stable while mem_wr_en=1 and mem_ready=0.
  - Address counter starts at base_addr, +1 per accepted write, wraps modulo 2^ADDR_W.
- Latency: word pushed into empty FIFO at edge N is presented with mem_wr_en at cycle N+1. done is asserted the cycle after the final accepted write.
- Push and pop in the same cycle on a non-empty FIFO leave occupancy unchanged.
- Synchronous rst mid-tile aborts immediately: FIFO flushed, no done, mem_wr_en=0 next cycle.

Test Plan:
- Basic tile:
  - Stimulus: start base=0x010 num=3; push words {01,02,03,04},{05,..},{09,..} with mem_ready=1.
  - Required: writes at 0x010,0x011,0x012 in order, data unchanged; done pulses once, one cycle after the third write.
- Memory stall:
  - Stimulus: mem_ready=0 for 6 cycles while PE pushes 5 words, num=5.
  - Required: res_ready drops after 4 pushes; mem_addr/data are held; all 5 words are written after release; overflow=0.
- Full-FIFO simultaneous push/pop:
  - Stimulus: FIFO full, mem_ready=1 and res_valid=1 in the same cycle.
  - Required: push accepted, occupancy stays 4, order preserved.
- Zero count:
  - Stimulus: start num=0.
  - Required: done the next cycle, no mem_wr_en, busy never 1.
- Address wrap and surplus word:
  - Stimulus: base=0x3FF num=2, then a third res_valid.
  - Required: addresses 0x3FF then 0x000; third word dropped; overflow=1.
- Reset mid-tile:
  - Stimulus: rst during RUN with 2 words queued.
  - Required: next cycle all outputs 0, no done; a new start runs cleanly.

Source files
------------

// File: rtl/result_writeback_if.sv
// PE-result and memory-write signals of one result_writeback instance.
// slave is the writeback block; master is the PE/memory environment.
interface result_writeback_if #(
    parameter int ADDR_W = 10
);
    logic              res_valid;
    logic [7:0]        res_data [0:3];
    logic              res_ready;
    logic              mem_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data_in [0:3];

    modport master (
        output res_valid, res_data, mem_ready,
        input  res_ready, mem_wr_en, mem_addr, mem_data_in
    );

    modport slave (
        input  res_valid, res_data, mem_ready,
        output res_ready, mem_wr_en, mem_addr, mem_data_in
    );
endinterface

// File: rtl/result_writeback.sv
// Buffers PE result words in a small FIFO and writes them to consecutive memory addresses.
// Latency: a push into an empty FIFO is presented one cycle later; mem_ready low holds the write and backs up res_ready.
module result_writeback #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    result_writeback_if.slave bus
);
    localparam int             PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    occ;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  push_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [31:0]       head;
    logic              full;
    logic              empty;
    logic              start_ok;
    logic              pop;
    logic              push;
    logic              drop;
    logic              last_wr;

    assign full     = (occ == DEPTH);
    assign empty    = (occ == '0);
    assign start_ok = start && (state == IDLE);
    assign head     = fifo_mem[rd_ptr];

    assign bus.mem_wr_en = (state == RUN) && !empty;
    assign pop           = bus.mem_wr_en && bus.mem_ready;
    assign bus.res_ready = (state == RUN) && (!full || pop);
    // Words beyond the programmed count are handshaken but discarded.
    assign push          = bus.res_valid && bus.res_ready && (push_cnt < num_q);
    assign drop          = bus.res_valid && !push;
    assign last_wr       = pop && ((wr_cnt + CNT_W'(1)) == num_q);

    assign busy = (state == RUN);
    assign done = (state == FIN);

    always_comb begin
        bus.mem_addr = bus.mem_wr_en ? addr_q : '0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_data_in[i] = bus.mem_wr_en ? head[8*(3-i) +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_words == '0) ? FIN : RUN;
            RUN:     if (last_wr) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            addr_q   <= '0;
            num_q    <= '0;
            push_cnt <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (start_ok) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                occ      <= '0;
                addr_q   <= base_addr;
                num_q    <= num_words;
                push_cnt <= '0;
                wr_cnt   <= '0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    push_cnt <= push_cnt + CNT_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    wr_cnt <= wr_cnt + CNT_W'(1);
                    addr_q <= addr_q + ADDR_W'(1);
                end
                case ({push, pop})
                    2'b10:   occ <= occ + (PTR_W + 1)'(1);
                    2'b01:   occ <= occ - (PTR_W + 1)'(1);
                    default: occ <= occ;
                endcase
            end
            // A word dropped in the start cycle still flags, so set wins over clear.
            overflow <= (overflow && !start_ok) || drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.res_data[0], bus.res_data[1], bus.res_data[2], bus.res_data[3]};
        end
    end
endmodule

// File: tb/tb_result_writeback.sv
// Directed and random stimulus for result_writeback against a queue-based model.
module tb_result_writeback;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] base_addr = '0;
    logic [9:0] num_words = '0;
    logic       busy, done, overflow;

    result_writeback_if #(.ADDR_W(10)) bus ();

    result_writeback #(.ADDR_W(10), .FIFO_DEPTH(4), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .overflow(overflow),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
    mphase_t     m_phase = M_IDLE;
    logic [31:0] m_q [$];
    int          m_base = 0, m_num = 0, m_writes = 0, m_pushes = 0;
    bit          m_ov = 0;

    typedef struct {int addr; logic [31:0] data; int cyc;} wr_t;
    wr_t wlog [$];
    bit  chk_en = 0;
    int  cyc_n = 0, done_cnt = 0, done_cyc = -1, start_cyc = -1, busy_seen = 0;
    int  wk = 0, acc_cnt = 0;

    function automatic logic [31:0] in_word();
        return {bus.res_data[0], bus.res_data[1], bus.res_data[2], bus.res_data[3]};
    endfunction

    function automatic logic [31:0] out_word();
        return {bus.mem_data_in[0], bus.mem_data_in[1], bus.mem_data_in[2], bus.mem_data_in[3]};
    endfunction

    function automatic int wl_addr(input int i);
        return (wlog.size() > i) ? wlog[i].addr : -1;
    endfunction

    function automatic logic [31:0] wl_data(input int i);
        return (wlog.size() > i) ? wlog[i].data : 32'hxxxxxxxx;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    // Every cycle: compare outputs with the model, log writes, then advance the model one edge.
    always @(negedge clk) begin
        bit          e_wr, e_rdy, pop, acc, drop;
        int          e_addr;
        logic [31:0] e_dat;
        logic [46:0] exp_v, got_v;
        if (chk_en) begin
            cyc_n++;
            e_wr   = (m_phase == M_RUN) && (m_q.size() > 0);
            pop    = e_wr && bus.mem_ready;
            e_rdy  = (m_phase == M_RUN) && ((m_q.size() < 4) || pop);
            e_addr = e_wr ? ((m_base + m_writes) % 1024) : 0;
            e_dat  = e_wr ? m_q[0] : 32'h0;
            exp_v  = {m_phase == M_RUN, m_phase == M_DONE, m_ov, e_rdy, e_wr, 10'(e_addr), e_dat};
            got_v  = {busy, done, overflow, bus.res_ready, bus.mem_wr_en, bus.mem_addr, out_word()};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_model cyc=%0d got=%h required=%h (busy,done,ovf,rdy,wr,addr,data)",
                         cyc_n, got_v, exp_v);
            end
            if (bus.mem_wr_en && bus.mem_ready)
                wlog.push_back('{addr: int'(bus.mem_addr), data: out_word(), cyc: cyc_n});
            if (done) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
            if (busy) busy_seen++;
            if (start && !rst && m_phase == M_IDLE) start_cyc = cyc_n;

            acc = bus.res_valid && e_rdy;
            if (rst) begin
                m_phase = M_IDLE; m_q.delete(); m_ov = 0;
                m_base = 0; m_num = 0; m_writes = 0; m_pushes = 0;
            end else begin
                drop = bus.res_valid && !(acc && m_pushes < m_num);
                case (m_phase)
                    M_IDLE: if (start) begin
                        m_base = int'(base_addr); m_num = int'(num_words);
                        m_writes = 0; m_pushes = 0; m_q.delete(); m_ov = 0;
                        m_phase = (num_words == 0) ? M_DONE : M_RUN;
                    end
                    M_RUN: begin
                        if (pop) begin
                            void'(m_q.pop_front());
                            m_writes++;
                        end
                        if (acc && m_pushes < m_num) begin
                            m_q.push_back(in_word());
                            m_pushes++;
                        end
                        if (m_writes == m_num) m_phase = M_DONE;
                    end
                    default: m_phase = M_IDLE;
                endcase
                if (drop) m_ov = 1;
            end
        end
    end

    task automatic set_word(input int k);
        for (int i = 0; i < 4; i++) bus.res_data[i] = 8'(4 * k + 1 + i);
    endtask

    // pv: 0 = idle, 1 = offer a word only when res_ready, 2 = assert res_valid regardless.
    task automatic cyc(input bit r, input bit st, input int base, input int num, input bit mr, input int pv);
        @(posedge clk);
        #1;
        rst = r; start = st; base_addr = 10'(base); num_words = 10'(num);
        bus.mem_ready = mr; bus.res_valid = 1'b0;
        set_word(wk);
        #1;
        if (pv == 2 || (pv == 1 && bus.res_ready)) bus.res_valid = 1'b1;
        if (bus.res_valid && bus.res_ready) begin
            wk++;
            acc_cnt++;
        end
    endtask

    task automatic clear_log();
        wlog.delete();
        done_cnt = 0; done_cyc = -1; busy_seen = 0; acc_cnt = 0; wk = 0;
    endtask

    initial begin
        bus.res_valid = 1'b0;
        bus.mem_ready = 1'b0;
        set_word(0);
        @(posedge clk);
        #1;
        chk_en = 1;
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset_outputs", {busy, done, overflow, bus.res_ready, bus.mem_wr_en, bus.mem_addr, out_word()}, 0);

        // basic tile
        clear_log();
        cyc(0, 1, 'h010, 3, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 1);
        repeat (6) cyc(0, 0, 0, 0, 1, 0);
        chk("basic_nwrites", wlog.size(), 3);
        for (int i = 0; i < 3; i++) chk("basic_addr", wl_addr(i), 'h010 + i);
        chk("basic_data0", wl_data(0), 32'h01020304);
        chk("basic_data1", wl_data(1), 32'h05060708);
        chk("basic_data2", wl_data(2), 32'h090a0b0c);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_done_cyc", done_cyc, (wlog.size() > 2) ? wlog[2].cyc + 1 : -1);

        // memory stall, then push on a full FIFO while it pops
        clear_log();
        cyc(0, 1, 'h100, 5, 0, 0);
        repeat (6) cyc(0, 0, 0, 0, 0, 1);
        chk("stall_pushes", acc_cnt, 4);
        chk("stall_ready_low", bus.res_ready, 0);
        chk("stall_addr_held", bus.mem_addr, 'h100);
        chk("stall_data_held", out_word(), 32'h01020304);
        cyc(0, 0, 0, 0, 1, 1);
        chk("full_pushpop_accepted", acc_cnt, 5);
        cyc(0, 0, 0, 0, 0, 1);
        chk("full_still_full", bus.res_ready, 0);
        chk("full_head_order", out_word(), 32'h05060708);
        repeat (8) cyc(0, 0, 0, 0, 1, 0);
        chk("stall_nwrites", wlog.size(), 5);
        for (int i = 0; i < 5; i++) chk("stall_addr", wl_addr(i), 'h100 + i);
        chk("stall_last_data", wl_data(4), 32'h11121314);
        chk("stall_overflow", overflow, 0);
        chk("stall_done_cnt", done_cnt, 1);

        // zero count
        clear_log();
        cyc(0, 1, 'h055, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 0, 1, 0);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_done_next", done_cyc - start_cyc, 1);
        chk("zero_no_writes", wlog.size(), 0);
        chk("zero_busy_never", busy_seen, 0);

        // address wrap and surplus word
        clear_log();
        cyc(0, 1, 'h3FF, 2, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 1);
        repeat (4) cyc(0, 0, 0, 0, 1, 0);
        chk("wrap_nwrites", wlog.size(), 2);
        chk("wrap_addr0", wl_addr(0), 'h3FF);
        chk("wrap_addr1", wl_addr(1), 'h000);
        chk("wrap_offered", acc_cnt, 3);
        chk("wrap_overflow", overflow, 1);
        chk("wrap_done_cnt", done_cnt, 1);

        // reset mid-tile
        clear_log();
        cyc(0, 1, 'h020, 6, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 1);
        chk("rst_queued", acc_cnt, 2);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rst_outputs", {busy, done, overflow, bus.res_ready, bus.mem_wr_en, bus.mem_addr, out_word()}, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 0);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_no_writes", wlog.size(), 0);
        clear_log();
        cyc(0, 1, 'h030, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        repeat (4) cyc(0, 0, 0, 0, 1, 0);
        chk("rst_restart_nwrites", wlog.size(), 1);
        chk("rst_restart_addr", wl_addr(0), 'h030);
        chk("rst_restart_data", wl_data(0), 32'h01020304);
        chk("rst_restart_done", done_cnt, 1);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int rnd, pv;
            bit r, st;
            r   = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 5) == 0);
            rnd = $urandom_range(0, 99);
            pv  = (rnd < 5) ? 2 : ((rnd < 65) ? 1 : 0);
            cyc(r, st, $urandom_range(0, 1023), $urandom_range(0, 9), ($urandom_range(0, 3) != 0), pv);
        end

        @(negedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
